// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game's player input path: state codes,
// switch count and the one-hot legality test used on the debounced code.
package jogo_pkg;

    localparam int N_CHAVES = 4;

    typedef enum logic [3:0] {
        ESPERA    = 4'd0,
        FILTRA    = 4'd1,
        REGISTRA  = 4'd2,
        INVALIDA  = 4'd3,
        SOLTA     = 4'd4,
        DESARMADO = 4'd5
    } estado_t;

    function automatic logic is_onehot(input logic [N_CHAVES-1:0] v);
        return ($countones(v) == 1);
    endfunction

endpackage

// File: rtl/contador_debounce.sv
// Saturating sample counter. zera clears it; zera together with conta restarts
// at 1 (the current sample counts); fim flags that MAX samples have been seen.
module contador_debounce #(
    parameter int MAX = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_W = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (zera) begin
            cnt <= conta ? W'(1) : '0;
        end else if (conta && (cnt != MAX_W)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign fim = (cnt == MAX_W);

endmodule

// File: rtl/leitor_jogada.sv
// Player switch reader: registers and debounces the switches, accepts one-hot
// presses once each, rejects stable multi-key presses, then waits for release.
module leitor_jogada
    import jogo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int RELEASE_CYCLES  = 2,
    parameter int N               = N_CHAVES
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         habilita,
    input  logic [N-1:0] chaves,
    output logic [N-1:0] jogada,
    output logic         jogada_feita,
    output logic         jogada_invalida,
    output logic         db_tem_jogada,
    output logic [3:0]   db_estado
);

    // Output contract: jogada_feita and jogada_invalida are single-cycle
    // pulses with no handshake back; jogada is valid from the jogada_feita
    // cycle and holds until the next accepted press or reset.

    estado_t      estado, estado_prox;
    logic [N-1:0] chaves_r;
    logic [N-1:0] referencia;
    logic         chaves_ok;
    logic         armado;
    logic         habilita_r;
    logic         tem;
    logic         ref_carrega;
    logic         pr_zera, pr_conta, pr_fim;
    logic         rel_ativo, rel_zera, rel_conta, rel_fim;

    assign tem = (chaves_r != '0);

    always_comb begin
        estado_prox = estado;
        ref_carrega = 1'b0;
        case (estado)
            ESPERA: begin
                // A key already down when habilita rises, or never released
                // since reset, must be let go before it can count.
                if (habilita && tem) begin
                    if (!habilita_r || !armado) begin
                        estado_prox = DESARMADO;
                    end else begin
                        estado_prox = FILTRA;
                        ref_carrega = 1'b1;
                    end
                end
            end
            FILTRA: begin
                if (!habilita || !tem) begin
                    estado_prox = ESPERA;
                end else if (chaves_r != referencia) begin
                    ref_carrega = 1'b1;
                end else if (pr_fim) begin
                    estado_prox = is_onehot(referencia) ? REGISTRA : INVALIDA;
                end
            end
            REGISTRA, INVALIDA: estado_prox = SOLTA;
            SOLTA, DESARMADO: begin
                if (rel_fim) estado_prox = ESPERA;
            end
            default: estado_prox = ESPERA;
        endcase
    end

    assign pr_conta  = tem && ((estado == ESPERA) || (estado == FILTRA));
    assign pr_zera   = !((estado == FILTRA) && habilita && (chaves_r == referencia));
    assign rel_ativo = (estado == SOLTA) || (estado == DESARMADO);
    assign rel_conta = rel_ativo && !tem;
    assign rel_zera  = !rel_ativo || tem;

    contador_debounce #(.MAX(DEBOUNCE_CYCLES)) u_cnt_press (
        .clock (clock),
        .reset (reset),
        .zera  (pr_zera),
        .conta (pr_conta),
        .fim   (pr_fim)
    );

    contador_debounce #(.MAX(RELEASE_CYCLES)) u_cnt_release (
        .clock (clock),
        .reset (reset),
        .zera  (rel_zera),
        .conta (rel_conta),
        .fim   (rel_fim)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= ESPERA;
            chaves_r        <= '0;
            chaves_ok       <= 1'b0;
            armado          <= 1'b0;
            habilita_r      <= 1'b0;
            referencia      <= '0;
            jogada          <= '0;
            jogada_feita    <= 1'b0;
            jogada_invalida <= 1'b0;
            db_tem_jogada   <= 1'b0;
        end else begin
            chaves_r   <= chaves;
            chaves_ok  <= 1'b1;
            habilita_r <= habilita;
            // chaves_r right after reset is the reset value, not a real sample.
            if (chaves_ok && !tem) armado <= 1'b1;
            estado <= estado_prox;
            if (ref_carrega) referencia <= chaves_r;
            jogada_feita    <= (estado_prox == REGISTRA);
            jogada_invalida <= (estado_prox == INVALIDA);
            if (estado_prox == REGISTRA) jogada <= referencia;
            db_tem_jogada <= tem;
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_leitor_jogada.sv
// Directed bench for leitor_jogada: accepted codes go through an expected
// queue that a negedge monitor drains on every jogada_feita pulse.
module tb_leitor_jogada;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         habilita = 1'b0;
    logic [N-1:0] chaves = '0;
    logic [N-1:0] jogada;
    logic         jogada_feita;
    logic         jogada_invalida;
    logic         db_tem_jogada;
    logic [3:0]   db_estado;

    int           total = 0;
    int           bad = 0;
    int           n_feita = 0;
    int           n_inval = 0;
    logic         pulso_ant = 1'b0;
    logic [N-1:0] exp_v;
    logic [N-1:0] exp_q[$];

    leitor_jogada #(
        .DEBOUNCE_CYCLES (3),
        .RELEASE_CYCLES  (2),
        .N               (N)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .chaves          (chaves),
        .jogada          (jogada),
        .jogada_feita    (jogada_feita),
        .jogada_invalida (jogada_invalida),
        .db_tem_jogada   (db_tem_jogada),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic jogar(input logic [N-1:0] v, input int on, input int off);
        chaves = v;
        repeat (on) tick();
        chaves = '0;
        repeat (off) tick();
    endtask

    // Scoreboard drain and pulse-shape checks.
    always @(negedge clock) begin
        if (!reset) begin
            if (jogada_feita) begin
                n_feita++;
                check("sb_nao_vazio", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    check("sb_jogada", 32'(jogada), 32'(exp_v));
                end
                check("feita_e_invalida", 32'(jogada_invalida), 32'd0);
            end
            if (jogada_invalida) n_inval++;
            if (jogada_feita || jogada_invalida) check("pulso_duplo", 32'(pulso_ant), 32'd0);
            pulso_ant = jogada_feita | jogada_invalida;
        end else begin
            pulso_ant = 1'b0;
        end
    end

    initial begin
        int f0;
        int i0;
        int seq[$];
        int t1_esp[5];
        logic [N-1:0] rodada[6];

        t1_esp = '{0, 1, 2, 4, 0};
        rodada = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0010};

        reset = 1'b1;
        repeat (10) tick();
        check("rst_jogada", 32'(jogada), 32'd0);
        check("rst_feita", 32'(jogada_feita), 32'd0);
        check("rst_invalida", 32'(jogada_invalida), 32'd0);
        check("rst_tem", 32'(db_tem_jogada), 32'd0);
        check("rst_estado", 32'(db_estado), 32'd0);

        reset = 1'b0;
        habilita = 1'b1;
        repeat (3) tick();
        check("idle_estado", 32'(db_estado), 32'd0);

        // T1 clean play with latency and state sequence
        f0 = n_feita;
        seq.push_back(int'(db_estado));
        exp_q.push_back(4'b0001);
        chaves = 4'b0001;
        for (int i = 1; i <= 12; i++) begin
            if (i == 6) chaves = '0;
            tick();
            if (int'(db_estado) != seq[$]) seq.push_back(int'(db_estado));
            if (i == 3) check("t1_tem", 32'(db_tem_jogada), 32'd1);
            if (i == 4) check("t1_feita_cedo", 32'(jogada_feita), 32'd0);
            if (i == 5) begin
                check("t1_latencia", 32'(jogada_feita), 32'd1);
                check("t1_jogada_valida", 32'(jogada), 32'b0001);
            end
            if (i == 6) check("t1_pulso_unico", 32'(jogada_feita), 32'd0);
        end
        check("t1_seq_len", 32'(seq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < seq.size()) check("t1_seq", 32'(seq[i]), 32'(t1_esp[i]));
        end
        check("t1_n_feita", 32'(n_feita - f0), 32'd1);
        check("t1_jogada", 32'(jogada), 32'b0001);

        // T2 bounce
        f0 = n_feita;
        i0 = n_inval;
        chaves = 4'b0010; tick();
        chaves = 4'b0000; tick();
        chaves = 4'b0010; tick();
        chaves = 4'b0000;
        repeat (8) tick();
        check("t2_n_feita", 32'(n_feita - f0), 32'd0);
        check("t2_n_inval", 32'(n_inval - i0), 32'd0);
        check("t2_jogada", 32'(jogada), 32'b0001);
        check("t2_estado", 32'(db_estado), 32'd0);

        // T3 invalid multi-key
        f0 = n_feita;
        i0 = n_inval;
        chaves = 4'b0110;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 5) check("t3_invalida", 32'(jogada_invalida), 32'd1);
        end
        chaves = '0;
        repeat (8) tick();
        check("t3_n_inval", 32'(n_inval - i0), 32'd1);
        check("t3_n_feita", 32'(n_feita - f0), 32'd0);
        check("t3_jogada", 32'(jogada), 32'b0001);

        // T4 held key, then key held across habilita rising
        f0 = n_feita;
        exp_q.push_back(4'b1000);
        jogar(4'b1000, 20, 8);
        check("t4_n_feita", 32'(n_feita - f0), 32'd1);
        check("t4_jogada", 32'(jogada), 32'b1000);
        check("t4_estado", 32'(db_estado), 32'd0);
        habilita = 1'b0;
        repeat (2) tick();
        chaves = 4'b0100;
        repeat (3) tick();
        check("t4_desab_estado", 32'(db_estado), 32'd0);
        f0 = n_feita;
        habilita = 1'b1;
        repeat (5) tick();
        check("t4_desarmado", 32'(db_estado), 32'd5);
        repeat (10) tick();
        check("t4_desarmado_fica", 32'(db_estado), 32'd5);
        check("t4_sem_pulso", 32'(n_feita - f0), 32'd0);
        chaves = '0;
        repeat (6) tick();
        check("t4_rearmado", 32'(db_estado), 32'd0);
        exp_q.push_back(4'b0100);
        jogar(4'b0100, 5, 6);
        check("t4_n_feita2", 32'(n_feita - f0), 32'd1);
        check("t4_jogada2", 32'(jogada), 32'b0100);

        // T5 round replay
        f0 = n_feita;
        for (int r = 0; r < 6; r++) begin
            exp_q.push_back(rodada[r]);
            jogar(rodada[r], 5, 5);
        end
        check("t5_n_feita", 32'(n_feita - f0), 32'd6);
        check("t5_jogada", 32'(jogada), 32'b0010);

        // T6 reset during FILTRA with key held
        chaves = 4'b0100;
        repeat (2) tick();
        check("t6_filtra", 32'(db_estado), 32'd1);
        reset = 1'b1;
        tick();
        check("t6_rst_jogada", 32'(jogada), 32'd0);
        check("t6_rst_feita", 32'(jogada_feita), 32'd0);
        check("t6_rst_invalida", 32'(jogada_invalida), 32'd0);
        check("t6_rst_tem", 32'(db_tem_jogada), 32'd0);
        check("t6_rst_estado", 32'(db_estado), 32'd0);
        reset = 1'b0;
        f0 = n_feita;
        repeat (12) tick();
        check("t6_held_sem_pulso", 32'(n_feita - f0), 32'd0);
        check("t6_held_jogada", 32'(jogada), 32'd0);
        chaves = '0;
        repeat (6) tick();
        exp_q.push_back(4'b0100);
        jogar(4'b0100, 5, 6);
        check("t6_n_feita", 32'(n_feita - f0), 32'd1);
        check("t6_jogada", 32'(jogada), 32'b0100);

        check("sb_vazio_fim", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
